// File: rtl/sipo_rx_shift_reg.sv
// sipo_rx_shift_reg
//   Serial-in, parallel-out receive shift register. Reassembles MSB-first
//   serial words and hands each completed word to a double-buffered holding
//   register that is read through a valid/ready handshake.
//
//   Optional feature macro: PARITY_EN
//     defined   : each frame is WIDTH data bits plus one even-parity bit.
//                 parity_err is latched with d_out.
//     undefined : each frame is WIDTH bits and parity_err is tied to 0.
//
//   Ports
//     clk        rising-edge clock
//     reset_n    asynchronous active-low reset
//     s_in       serial data bit, sampled when s_en=1
//     s_en       bit strobe, one bit accepted per strobe cycle
//     s_sync     word alignment: drops any partial word; a bit strobed in
//                the same cycle starts a new word
//     d_out      received word, MSB = first bit received
//     d_valid    d_out holds an unconsumed word
//     d_ready    consumer accepts d_out when d_valid && d_ready
//     overrun    sticky: a completed word was dropped
//     ovr_clr    synchronous clear of overrun (a new overrun wins)
//     parity_err parity result for the word on d_out
module sipo_rx_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             s_in,
   input  logic             s_en,
   input  logic             s_sync,
   output logic [WIDTH-1:0] d_out,
   output logic             d_valid,
   input  logic             d_ready,
   output logic             overrun,
   input  logic             ovr_clr,
   output logic             parity_err
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state, state_nxt, state_base;
   logic [CW-1:0]    cnt, cnt_nxt, cnt_base;
   logic [WIDTH-1:0] sh, sh_nxt;
   logic             complete;
   logic             load;
   logic             drop;
`ifdef PARITY_EN
   logic             perr_nxt;
`endif

   // s_sync realigns before the strobe is processed, so the FSM works from
   // IDLE/cnt=0 in that cycle. The parity bit is never shifted in, so the
   // completed word is sh_nxt in both frame formats.
   always_comb begin
      state_base = s_sync ? IDLE : state;
      cnt_base   = s_sync ? '0 : cnt;
      state_nxt  = state_base;
      cnt_nxt    = cnt_base;
      sh_nxt     = sh;
      complete   = 1'b0;
`ifdef PARITY_EN
      perr_nxt   = 1'b0;
`endif
      if (s_en) begin
         case (state_base)
            IDLE, SHIFT: begin
               sh_nxt = {sh[WIDTH-2:0], s_in};
               if (cnt_base == CW'(WIDTH - 1)) begin
`ifdef PARITY_EN
                  state_nxt = PAR;
                  cnt_nxt   = CW'(WIDTH);
`else
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
                  complete  = 1'b1;
`endif
               end else begin
                  state_nxt = SHIFT;
                  cnt_nxt   = cnt_base + CW'(1);
               end
            end
`ifdef PARITY_EN
            PAR: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               complete  = 1'b1;
               perr_nxt  = ^{sh, s_in};
            end
`endif
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Holding register is free if empty or being consumed this cycle.
   assign load = complete & (~d_valid | d_ready);
   assign drop = complete & d_valid & ~d_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         sh      <= '0;
         d_out   <= '0;
         d_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sh    <= sh_nxt;
         if (load) begin
            d_out   <= sh_nxt;
            d_valid <= 1'b1;
         end else if (d_ready) begin
            d_valid <= 1'b0;
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

`ifdef PARITY_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         parity_err <= 1'b0;
      end else if (load) begin
         parity_err <= perr_nxt;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
